// File: rtl/piso_frame_scheduler.sv
// Round-robin scheduler and serial framer: grants one pending channel at a time
// and shifts out START, channel ID (LSB-first), data word (LSB-first), STOP.
module piso_frame_scheduler #(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 12,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*DATA_W-1:0]   data,
  output logic [N_CH-1:0]          ack,
  output logic                     serial_out,
  output logic                     frame_active,
  output logic [CH_W-1:0]          sel
);

  localparam int SH_W    = CH_W + DATA_W;
  localparam int CNT_MAX = (DATA_W > CH_W) ? DATA_W : CH_W;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ID, S_DATA, S_STOP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SH_W-1:0]    r_shift;
  logic [CH_W-1:0]    r_ptr;
  logic [CH_W-1:0]    r_sel;
  logic [N_CH-1:0]    r_ack;
  logic               r_serial;
  logic               r_active;

  state_t             w_stateNext;
  logic [CNT_W-1:0]   w_cntNext;
  logic [SH_W-1:0]    w_shiftNext;
  logic [CH_W-1:0]    w_ptrNext;
  logic [CH_W-1:0]    w_selNext;
  logic [N_CH-1:0]    w_ackNext;
  logic               w_serialNext;
  logic               w_activeNext;
  logic               w_found;
  logic               w_grant;
  logic [CH_W-1:0]    w_grantIdx;

  // Search upward from the rotating pointer; only IDLE and STOP may grant.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_grantIdx = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!w_found && req[idx[CH_W-1:0]]) begin
        w_found    = 1'b1;
        w_grantIdx = idx[CH_W-1:0];
      end
    end
    w_grant = w_found && en && ((r_state == S_IDLE) || (r_state == S_STOP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_ack    <= '0;
      r_serial <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_shift  <= w_shiftNext;
      r_ptr    <= w_ptrNext;
      r_sel    <= w_selNext;
      r_ack    <= w_ackNext;
      r_serial <= w_serialNext;
      r_active <= w_activeNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_stateNext = S_START;
          w_cntNext   = '0;
        end
      end
      S_START: begin
        w_stateNext = S_ID;
        w_cntNext   = '0;
      end
      S_ID: begin
        if (r_cnt == CNT_W'(CH_W - 1)) begin
          w_stateNext = S_DATA;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_stateNext = S_STOP;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        w_stateNext = w_grant ? S_START : S_IDLE;
        w_cntNext   = '0;
      end
      default: begin
        w_stateNext = S_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Outputs are computed for the upcoming state so they appear registered in that state's cycle.
  always_comb begin
    w_serialNext = 1'b0;
    w_activeNext = (w_stateNext != S_IDLE);
    w_ackNext    = '0;
    w_selNext    = r_sel;
    w_ptrNext    = r_ptr;
    w_shiftNext  = r_shift;
    if (w_grant) begin
      w_ackNext   = {{(N_CH-1){1'b0}}, 1'b1} << w_grantIdx;
      w_selNext   = w_grantIdx;
      w_ptrNext   = (w_grantIdx == CH_W'(N_CH - 1)) ? '0 : w_grantIdx + 1'b1;
      w_shiftNext = {data[int'(w_grantIdx)*DATA_W +: DATA_W], w_grantIdx};
    end
    case (w_stateNext)
      S_START: w_serialNext = 1'b1;
      S_ID, S_DATA: begin
        w_serialNext = r_shift[0];
        w_shiftNext  = r_shift >> 1;
      end
      default: w_serialNext = 1'b0;
    endcase
  end

  assign ack          = r_ack;
  assign serial_out   = r_serial;
  assign frame_active = r_active;
  assign sel          = r_sel;

endmodule

// File: tb/tb_piso_frame_scheduler.sv
// Directed bench for piso_frame_scheduler: each frame is checked bit by bit
// against a frame image built from the expected channel ID and captured word.
module tb_piso_frame_scheduler;

  localparam int N_CH   = 4;
  localparam int DATA_W = 12;

  logic                   clk;
  logic                   rst_n;
  logic                   en;
  logic [N_CH-1:0]        req;
  logic [N_CH*DATA_W-1:0] data;
  logic [N_CH-1:0]        ack;
  logic                   serial_out;
  logic                   frame_active;
  logic [1:0]             sel;

  int assertCount;
  int failCount;
  logic [15:0] bits;

  piso_frame_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .req          (req),
    .data         (data),
    .ack          (ack),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .sel          (sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] reqV, input logic enV);
    req = reqV;
    en  = enV;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Walks the 16 cycles of one frame starting at the next falling edge; after the
  // START cycle the request/enable inputs are updated as the step requires.
  task automatic checkFrame(input int ch, input logic [11:0] word,
                            input logic [N_CH-1:0] dropMask, input logic [N_CH-1:0] raiseMask,
                            input logic newEn, output logic [15:0] seen);
    logic [15:0]     expv;
    logic [1:0]      chBits;
    logic [N_CH-1:0] oneHot;
    chBits = 2'(ch);
    oneHot = 4'b0001 << ch;
    expv   = {1'b0, word, chBits, 1'b1};
    seen   = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seen[i] = serial_out;
      checkOutput($sformatf("ch%0d_bit%0d_line", ch, i), 32'(serial_out), 32'(expv[i]));
      checkOutput($sformatf("ch%0d_bit%0d_active", ch, i), 32'(frame_active), 32'd1);
      checkOutput($sformatf("ch%0d_bit%0d_ack", ch, i), 32'(ack), (i == 0) ? 32'(oneHot) : 32'd0);
      checkOutput($sformatf("ch%0d_bit%0d_sel", ch, i), 32'(sel), 32'(ch));
      if (i == 0) begin
        req = (req & ~dropMask) | raiseMask;
        en  = newEn;
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    data  = '0;

    $display("[TB] reset values");
    @(negedge clk);
    checkOutput("rst_line", 32'(serial_out), 32'd0);
    checkOutput("rst_active", 32'(frame_active), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single request on ch2");
    data[2*DATA_W +: DATA_W] = 12'hA5C;
    applyStimulus(4'b0100, 1'b1);
    checkFrame(2, 12'hA5C, 4'b0100, 4'b0000, 1'b1, bits);
    checkOutput("t1_sequence", 32'(bits), 32'h52E5);
    @(negedge clk);
    checkOutput("t1_idle_line", 32'(serial_out), 32'd0);
    checkOutput("t1_idle_active", 32'(frame_active), 32'd0);
    checkOutput("t1_idle_ack", 32'(ack), 32'd0);
    checkOutput("t1_idle_sel_hold", 32'(sel), 32'd2);

    $display("[TB] all channels requesting continuously");
    applyReset();
    data = {12'h444, 12'h333, 12'h222, 12'h111};
    applyStimulus(4'b1111, 1'b1);
    checkFrame(0, 12'h111, 4'b0000, 4'b0000, 1'b1, bits);
    checkFrame(1, 12'h222, 4'b0000, 4'b0000, 1'b1, bits);
    checkFrame(2, 12'h333, 4'b0000, 4'b0000, 1'b1, bits);
    checkFrame(3, 12'h444, 4'b0000, 4'b0000, 1'b1, bits);
    checkFrame(0, 12'h111, 4'b1111, 4'b0000, 1'b1, bits);
    @(negedge clk);
    checkOutput("t2_idle_active", 32'(frame_active), 32'd0);
    checkOutput("t2_idle_ack", 32'(ack), 32'd0);

    $display("[TB] round-robin between ch0 and ch3, ch1 joins");
    applyReset();
    data = {12'hC03, 12'h000, 12'h7E1, 12'h3A0};
    applyStimulus(4'b1001, 1'b1);
    checkFrame(0, 12'h3A0, 4'b0000, 4'b0000, 1'b1, bits);
    checkFrame(3, 12'hC03, 4'b0000, 4'b0000, 1'b1, bits);
    checkFrame(0, 12'h3A0, 4'b0000, 4'b0010, 1'b1, bits);
    checkFrame(1, 12'h7E1, 4'b0010, 4'b0000, 1'b1, bits);
    checkFrame(3, 12'hC03, 4'b0000, 4'b0000, 1'b1, bits);
    checkFrame(0, 12'h3A0, 4'b1001, 4'b0000, 1'b1, bits);
    @(negedge clk);
    checkOutput("t3_idle_active", 32'(frame_active), 32'd0);

    $display("[TB] data change right after capture");
    data[1*DATA_W +: DATA_W] = 12'h001;
    applyStimulus(4'b0010, 1'b1);
    @(posedge clk);
    #1 data[1*DATA_W +: DATA_W] = 12'hFFF;
    checkFrame(1, 12'h001, 4'b0010, 4'b0000, 1'b1, bits);
    checkOutput("t4_data_bits", 32'(bits[14:3]), 32'h001);

    $display("[TB] enable gating");
    data[0 +: DATA_W] = 12'h9C6;
    applyStimulus(4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_gated%0d_ack", i), 32'(ack), 32'd0);
      checkOutput($sformatf("t5_gated%0d_line", i), 32'(serial_out), 32'd0);
      checkOutput($sformatf("t5_gated%0d_active", i), 32'(frame_active), 32'd0);
    end
    en = 1'b1;
    checkFrame(0, 12'h9C6, 4'b0000, 4'b0000, 1'b0, bits);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_after%0d_ack", i), 32'(ack), 32'd0);
      checkOutput($sformatf("t5_after%0d_active", i), 32'(frame_active), 32'd0);
    end
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] asynchronous reset during data phase");
    data = {12'h0F0, 12'hFFF, 12'h5A3, 12'h000};
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("t6_start_ack", 32'(ack), 32'h4);
    req = '0;
    repeat (5) @(negedge clk);
    checkOutput("t6_pre_line", 32'(serial_out), 32'd1);
    checkOutput("t6_pre_active", 32'(frame_active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_line", 32'(serial_out), 32'd0);
    checkOutput("t6_rst_active", 32'(frame_active), 32'd0);
    checkOutput("t6_rst_ack", 32'(ack), 32'd0);
    checkOutput("t6_rst_sel", 32'(sel), 32'd0);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    checkFrame(1, 12'h5A3, 4'b1010, 4'b0000, 1'b1, bits);
    @(negedge clk);
    checkOutput("t6_idle_active", 32'(frame_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/piso_frame_scheduler.md
# piso_frame_scheduler

Round-robin scheduler and framer that shares one serial output line among N_CH spectrogram channel results (12-bit band energies). It arbitrates among pending requests, captures the winning word, and shifts out a framed serial word: start bit, channel ID, then data LSB-first, then stop bit. It sits between the per-band energy accumulators and the chip's serial output pin, replacing free-running load/shift control with a sequenced, handshaked transmitter.

## Interface
- N_CH, 4, number of requesting channels (2..8)
- DATA_W, 12, data word width
- CH_W, $clog2(N_CH), channel ID field width (derived, not overridable)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  when low, no new frame starts; a frame in progress completes
- req  in  N_CH  per-channel request, level, held until ack
- data  in  N_CH*DATA_W  channel k word at bits [k*DATA_W +: DATA_W], stable while req[k] high
- ack  out  N_CH  one-hot, one-cycle pulse when channel word is captured
- serial_out  out  1  framed serial line, idles low
- frame_active  out  1  high for every cycle of a frame (start..stop)
- sel  out  CH_W  ID of the channel currently being transmitted (holds last value when idle)

## Operation
- Clock is one signal; reset is asynchronous and active-low. Every output is registered.
- Frame: START (1 cycle, line=1) -> ID (CH_W cycles, channel ID LSB-first) -> DATA (DATA_W cycles, word LSB-first) -> STOP (1 cycle, line=0). Frame length F = CH_W+DATA_W+2 (16 at defaults).
- FSM states: IDLE, START, ID, DATA, STOP. One internal counter tracks bit index in ID/DATA and resets on each state entry.
- Arbitration happens in IDLE and in STOP when en=1 and |req. Search starts at pointer p and ascends mod N_CH; first set req wins.
- On grant to k: capture data[k] into shift register, load sel=k, pulse ack[k], set p=(k+1) mod N_CH, next state START.
- STOP with a grant goes straight to START: back-to-back frames with no idle gap. STOP with no grant, or en=0, goes to IDLE.
- A req still high the cycle after its ack is a new request; the rotated pointer serves other pending channels first.
- Captured data is frozen; changes on data[] after ack have no effect on the current frame.
- en deasserted mid-frame: frame completes normally, and no arbitration occurs at STOP.

## Timing
- Reset values: serial_out=0, frame_active=0, ack=0, sel=0, p=0, state IDLE, shift register 0.
- Reset mid-frame aborts immediately: line low, frame_active low, no ack. After release, arbitration restarts with p=0.
- Latency: req[k] high at edge t with FSM in IDLE -> ack[k]=1, frame_active=1, serial_out=1 (START) during cycle t+1. First ID bit is in t+2. First data bit is in t+2+CH_W. STOP is in t+F.
- ack[k] is high exactly during the START cycle of its frame.
- Sustained full load: one frame every F cycles, frame_active continuously high.
- Simultaneous requests: exactly one ack per frame. Lowest index at or after p wins.
- req dropped before grant: no frame, no ack. No other state change.

## Test plan
- Single request: p=0, req=4'b0100, data[2]=0xA5C. Expected: ack[2] for 1 cycle; serial sequence 1, 0,1, 0,0,1,1,1,0,1,0,0,1,0,1, 0; sel=2; then idle line 0.
- All four request continuously: grants go 0,1,2,3,0. Frames are back-to-back with frame_active never dropping. Each ack is spaced 16 cycles apart.
- Round-robin fairness: req[0] and req[3] held high with p=0 -> order 0,3,0,3. Ch1 raised mid-frame is served before ch0's next turn when p=1.
- Data change after ack: data[1]=0x001 captured, then changed to 0xFFF the next cycle. Expected: data bits transmitted are 1 then 0 x11.
- en gating: en=0 with req=4'b0001 -> no ack, line 0. en raised -> ack next cycle. en dropped mid-frame -> frame completes, then IDLE despite req still high.
- Reset mid-DATA: rst_n pulsed low asynchronously. Expected: outputs go to reset values immediately. After release with req=4'b1010, first grant goes to ch1 (p reset to 0).
